// File: rtl/parallel_pe.sv
// 32-lane signed 16-bit multiply-accumulate element: multiply, two-stage adder
// tree, then segment accumulation framed by ctl (first/last).
module parallel_pe (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] neuron,
    input  logic [511:0] weight,
    input  logic [1:0]   ctl,
    input  logic         vld_i,
    output logic [31:0]  result,
    output logic         vld_o
);

    logic signed [31:0] p [32];
    logic               s1_vld;
    logic [1:0]         s1_ctl;

    logic signed [31:0] l1 [16];
    logic signed [31:0] l2 [8];
    logic signed [31:0] l3 [4];

    logic signed [31:0] s2_part [4];
    logic               s2_vld;
    logic [1:0]         s2_ctl;

    logic signed [31:0] sum;
    logic [31:0]        s3_sum;
    logic               s3_vld;
    logic [1:0]         s3_ctl;

    logic [31:0]        acc;
    logic [31:0]        acc_next;

    // Stage 1: lane products; data registers only load on a valid beat
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= vld_i;
        end
        if (vld_i) begin
            s1_ctl <= ctl;
            for (int unsigned i = 0; i < 32; i++) begin
                p[i] <= $signed(neuron[16*i +: 16]) * $signed(weight[16*i +: 16]);
            end
        end
    end

    // First three tree levels (32 -> 4) in front of the mid-tree register
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            l1[i] = p[2*i] + p[2*i+1];
        end
        for (int unsigned i = 0; i < 8; i++) begin
            l2[i] = l1[2*i] + l1[2*i+1];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            l3[i] = l2[2*i] + l2[2*i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
        end
        if (s1_vld) begin
            s2_ctl <= s1_ctl;
            for (int unsigned i = 0; i < 4; i++) begin
                s2_part[i] <= l3[i];
            end
        end
    end

    always_comb begin
        sum = (s2_part[0] + s2_part[1]) + (s2_part[2] + s2_part[3]);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s3_vld <= 1'b0;
        end else begin
            s3_vld <= s2_vld;
        end
        if (s2_vld) begin
            s3_ctl <= s2_ctl;
            s3_sum <= sum;
        end
    end

    // Stage 3: first beat restarts the accumulator, otherwise keep adding
    always_comb begin
        acc_next = s3_ctl[0] ? s3_sum : acc + s3_sum;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc    <= '0;
            result <= '0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= 1'b0;
            if (s3_vld) begin
                acc <= acc_next;
                if (s3_ctl[1]) begin
                    result <= acc_next;
                    vld_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_parallel_pe.sv
// Directed bench for parallel_pe: table of beats with expected segment results,
// pulse timing checked against the 3-edge latency, plus a mid-segment reset.
module tb_parallel_pe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] neuron;
    logic [511:0] weight;
    logic [1:0]   ctl;
    logic         vld_i;
    logic [31:0]  result;
    logic         vld_o;

    always #5 clk = ~clk;

    parallel_pe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .result (result),
        .vld_o  (vld_o)
    );

    typedef struct {
        logic [15:0] n;
        logic [15:0] w;
        bit          all_lanes;
        logic [1:0]  ctl;
        int unsigned gap;
        bit          pulse;
        logic [31:0] exp;
    } vec_t;

    localparam int unsigned NVEC = 29;
    vec_t vec [NVEC];
    int unsigned nv;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [31:0] got_res  [$];
    int unsigned got_edge [$];
    logic [31:0] exp_res  [$];
    int unsigned exp_edge [$];

    always @(negedge clk) begin
        if (vld_o === 1'b1) begin
            got_res.push_back(result);
            got_edge.push_back(edge_cnt);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] n, input logic [15:0] w, input bit all,
                                input logic [1:0] c, input int unsigned gap,
                                input bit pulse, input logic [31:0] exp);
        vec_t v;
        v.n = n; v.w = w; v.all_lanes = all; v.ctl = c;
        v.gap = gap; v.pulse = pulse; v.exp = exp;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vec[nv] = v;
        nv++;
    endtask

    task automatic drive_beat(input vec_t v);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            neuron[16*i +: 16] = (v.all_lanes || i == 0) ? v.n : 16'h0000;
            weight[16*i +: 16] = (v.all_lanes || i == 0) ? v.w : 16'h0000;
        end
        ctl   = v.ctl;
        vld_i = 1'b1;
        // sampled at edge edge_cnt+1, result visible after edge edge_cnt+4
        if (v.pulse) begin
            exp_res.push_back(v.exp);
            exp_edge.push_back(edge_cnt + 4);
        end
    endtask

    // Bubbles carry junk data and ctl=11 to show they are ignored
    task automatic bubble(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            vld_i  = 1'b0;
            neuron = {16{$urandom()}};
            weight = {16{$urandom()}};
            ctl    = 2'b11;
        end
    endtask

    task automatic check_pulses(input string tag);
        int unsigned m;
        bubble(8);
        check32({tag, "_pulse_count"}, got_res.size(), exp_res.size());
        m = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
        for (int unsigned i = 0; i < m; i++) begin
            check32($sformatf("%s_result[%0d]", tag, i), got_res[i], exp_res[i]);
            check32($sformatf("%s_edge[%0d]", tag, i), got_edge[i], exp_edge[i]);
        end
        got_res.delete(); got_edge.delete();
        exp_res.delete(); exp_edge.delete();
    endtask

    initial begin
        rst_n  = 1'b1;
        vld_i  = 1'b0;
        neuron = '0;
        weight = '0;
        ctl    = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check32("reset_result", result, 32'h0);
        check32("reset_vld_o", {31'b0, vld_o}, 32'h0);

        nv = 0;
        // single-beat segment: 32 lanes of 1*2
        add(mk(16'd1, 16'd2, 1, 2'b11, 0, 1, 32'd64));
        // four beats, lane0 only 3*5, with a bubble inside the segment
        add(mk(16'd3, 16'd5, 0, 2'b01, 0, 0, 32'd0));
        add(mk(16'd3, 16'd5, 0, 2'b00, 1, 0, 32'd0));
        add(mk(16'd3, 16'd5, 0, 2'b00, 0, 0, 32'd0));
        add(mk(16'd3, 16'd5, 0, 2'b10, 0, 1, 32'd60));
        // signed: -2*7 on all lanes, two beats
        add(mk(16'hFFFE, 16'd7, 1, 2'b01, 0, 0, 32'd0));
        add(mk(16'hFFFE, 16'd7, 1, 2'b10, 0, 1, 32'hFFFFFC80));
        // back-to-back segments of length 3, 1, 5 with no gaps, then with gaps
        for (int unsigned g = 0; g < 2; g++) begin
            add(mk(16'd1, 16'd1, 1, 2'b01, g, 0, 32'd0));
            add(mk(16'd1, 16'd1, 1, 2'b00, g, 0, 32'd0));
            add(mk(16'd1, 16'd1, 1, 2'b10, g, 1, 32'd96));
            add(mk(16'd100, 16'hFFFD, 0, 2'b11, g, 1, 32'hFFFFFED4));
            add(mk(16'd2, 16'd3, 1, 2'b01, g, 0, 32'd0));
            add(mk(16'd2, 16'd3, 1, 2'b00, g, 0, 32'd0));
            add(mk(16'd2, 16'd3, 1, 2'b00, g, 0, 32'd0));
            add(mk(16'd2, 16'd3, 1, 2'b00, g, 0, 32'd0));
            add(mk(16'd2, 16'd3, 1, 2'b10, g, 1, 32'd960));
        end
        // wrap: 32 * 0x3FFF0001 * 3 beats, modulo 2^32
        add(mk(16'h7FFF, 16'h7FFF, 1, 2'b01, 0, 0, 32'd0));
        add(mk(16'h7FFF, 16'h7FFF, 1, 2'b00, 0, 0, 32'd0));
        add(mk(16'h7FFF, 16'h7FFF, 1, 2'b10, 0, 1, 32'hFFA00060));
        // beat with first=0 and no open segment accumulates onto the stale acc
        add(mk(16'd1, 16'd1, 0, 2'b10, 2, 1, 32'hFFA00061));

        for (int unsigned i = 0; i < nv; i++) begin
            drive_beat(vec[i]);
            bubble(vec[i].gap);
        end
        check_pulses("table");

        // reset after beat 2 of a 4-beat segment: nothing may come out
        drive_beat(mk(16'd9, 16'd9, 1, 2'b01, 0, 0, 32'd0));
        drive_beat(mk(16'd9, 16'd9, 1, 2'b00, 0, 0, 32'd0));
        @(negedge clk);
        vld_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_pulses("midreset");
        check32("midreset_result", result, 32'h0);

        // full segment after reset
        drive_beat(mk(16'd1, 16'd2, 1, 2'b01, 0, 0, 32'd0));
        drive_beat(mk(16'd1, 16'd2, 1, 2'b10, 0, 1, 32'd128));
        check_pulses("postreset");
        check32("result_hold", result, 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
